// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the sequence detector.
// Words arrive over a valid/ready handshake into a one-word holding buffer,
// then shift out one bit per clock on x. The holding buffer lets the next
// word load on the same edge the current word's last bit ends, so a stream
// of words produces a continuous x_valid with no idle bit between words.
module bit_serializer #(
    parameter int   WIDTH     = 8,
    parameter bit   MSB_FIRST = 1'b1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             word_done,
    output logic             busy
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRELAST_IDX = CW'(WIDTH - 2);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_hbuf;
    logic             r_hvalid;
    logic [WIDTH-1:0] r_sreg;
    logic [CW-1:0]    r_cnt;
    logic             r_x;
    logic             r_xValid;
    logic             r_wordDone;

    state_t           w_stateNext;
    logic [WIDTH-1:0] w_hbufNext;
    logic             w_hvalidNext;
    logic [WIDTH-1:0] w_sregNext;
    logic [CW-1:0]    w_cntNext;
    logic             w_xNext;
    logic             w_xValidNext;
    logic             w_wordDoneNext;

    logic             w_lastBit;
    logic             w_loadNow;
    logic             w_ready;
    logic             w_accept;

    // The shifter is free to take the buffered word when idle, or on the
    // edge that ends the current word's last bit.
    assign w_lastBit = (r_state == SHIFT) && (r_cnt == LAST_IDX);
    assign w_loadNow = r_hvalid && ((r_state == IDLE) || w_lastBit);
    assign w_ready   = (!r_hvalid || w_loadNow) && !rst;
    assign w_accept  = din_valid && w_ready;

    assign din_ready = w_ready;
    assign x         = r_x;
    assign x_valid   = r_xValid;
    assign word_done = r_wordDone;
    assign busy      = r_xValid || r_hvalid;

    // Next-state and next-output logic: buffer fill/drain, load, shift, and
    // the registered x / x_valid / word_done values for the coming cycle.
    always_comb begin
        w_stateNext    = r_state;
        w_hbufNext     = r_hbuf;
        w_hvalidNext   = r_hvalid;
        w_sregNext     = r_sreg;
        w_cntNext      = r_cnt;
        w_xValidNext   = r_xValid;
        w_wordDoneNext = 1'b0;
        w_xNext        = IDLE_BIT;

        if (w_accept) begin
            w_hbufNext   = din;
            w_hvalidNext = 1'b1;
        end else if (w_loadNow) begin
            w_hvalidNext = 1'b0;
        end

        if (w_loadNow) begin
            w_sregNext   = r_hbuf;
            w_cntNext    = '0;
            w_stateNext  = SHIFT;
            w_xValidNext = 1'b1;
        end else if (r_state == SHIFT) begin
            if (!w_lastBit) begin
                w_cntNext      = r_cnt + CW'(1);
                w_xValidNext   = 1'b1;
                w_wordDoneNext = (r_cnt == PRELAST_IDX);
                if (MSB_FIRST) begin
                    w_sregNext = {r_sreg[WIDTH-2:0], r_sreg[WIDTH-1]};
                end else begin
                    w_sregNext = {r_sreg[0], r_sreg[WIDTH-1:1]};
                end
            end else begin
                w_stateNext  = IDLE;
                w_xValidNext = 1'b0;
            end
        end

        if (w_xValidNext) begin
            w_xNext = MSB_FIRST ? w_sregNext[WIDTH-1] : w_sregNext[0];
        end
    end

    // State register; reset discards both the shifting and the buffered word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_hbuf     <= '0;
            r_hvalid   <= 1'b0;
            r_sreg     <= '0;
            r_cnt      <= '0;
            r_x        <= IDLE_BIT;
            r_xValid   <= 1'b0;
            r_wordDone <= 1'b0;
        end else begin
            r_state    <= w_stateNext;
            r_hbuf     <= w_hbufNext;
            r_hvalid   <= w_hvalidNext;
            r_sreg     <= w_sregNext;
            r_cnt      <= w_cntNext;
            r_x        <= w_xNext;
            r_xValid   <= w_xValidNext;
            r_wordDone <= w_wordDoneNext;
        end
    end

endmodule

// File: tb/tb_bit_serializer.sv
// Testbench for bit_serializer. Two instances (MSB-first and LSB-first) share
// one stimulus stream. The reference model is a word schedule: each accepted
// word gets an accept edge and a start edge (one edge after accept, or when
// the previous word ends, whichever is later); every expected output is
// derived from that schedule with plain arithmetic.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         din_valid;

    logic         readyM, xM, xValidM, doneM, busyM;
    logic         readyL, xL, xValidL, doneL, busyL;

    int           nCompared;
    int           nMismatched;
    int           cyc;

    // Reference model: schedule of accepted words
    logic [W-1:0] wData[$];
    int           wAcc[$];
    int           wStart[$];
    int           liveFrom;
    int           nextFree;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dutM (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(readyM), .x(xM), .x_valid(xValidM),
        .word_done(doneM), .busy(busyM)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dutL (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(readyL), .x(xL), .x_valid(xValidL),
        .word_done(doneL), .busy(busyL)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed bit against its expected value
    task automatic compareBit(input string tag, input logic obs, input logic exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s at edge %0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Ready for edge e: no word sits in the buffer across edge e
    function automatic logic modelReady(input int e, input logic r);
        logic rdy;
        rdy = !r;
        for (int i = liveFrom; i < wData.size(); i++) begin
            if (wAcc[i] < e && wStart[i] > e) rdy = 1'b0;
        end
        return rdy;
    endfunction

    // Check outputs that follow edge cyc against the schedule
    task automatic checkOutput();
        logic         expValid, expDone, expBusy, expXM, expXL;
        logic [W-1:0] d;
        int           k;
        expValid = 1'b0;
        expDone  = 1'b0;
        expBusy  = 1'b0;
        expXM    = 1'b0;
        expXL    = 1'b0;
        for (int i = liveFrom; i < wData.size(); i++) begin
            if (wStart[i] <= cyc && cyc < wStart[i] + W) begin
                k        = cyc - wStart[i];
                d        = wData[i];
                expValid = 1'b1;
                expXM    = d[W-1-k];
                expXL    = d[k];
                expDone  = (k == W - 1);
            end
            if (wAcc[i] <= cyc && cyc < wStart[i]) expBusy = 1'b1;
        end
        expBusy = expBusy || expValid;
        compareBit("x_msb",       xM,      expXM);
        compareBit("x_lsb",       xL,      expXL);
        compareBit("x_valid_msb", xValidM, expValid);
        compareBit("x_valid_lsb", xValidL, expValid);
        compareBit("done_msb",    doneM,   expDone);
        compareBit("done_lsb",    doneL,   expDone);
        compareBit("busy_msb",    busyM,   expBusy);
        compareBit("busy_lsb",    busyL,   expBusy);
    endtask

    // Drive one cycle of inputs, check ready before the edge, update the
    // schedule at the edge, then check the registered outputs
    task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d);
        logic expReady;
        int   s;
        @(negedge clk);
        rst       = r;
        din_valid = v;
        din       = d;
        #1;
        expReady = modelReady(cyc + 1, r);
        compareBit("ready_msb", readyM, expReady);
        compareBit("ready_lsb", readyL, expReady);
        @(posedge clk);
        cyc++;
        if (r) begin
            liveFrom = wData.size();
            nextFree = 0;
        end else if (v && expReady) begin
            s = (cyc + 1 > nextFree) ? cyc + 1 : nextFree;
            wData.push_back(d);
            wAcc.push_back(cyc);
            wStart.push_back(s);
            nextFree = s + W;
        end
        #1;
        checkOutput();
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        cyc         = 0;
        liveFrom    = 0;
        nextFree    = 0;
        rst         = 1'b1;
        din_valid   = 1'b0;
        din         = '0;

        // Reset
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);

        // Single word 1011_0110 with one valid pulse, then drain
        applyStimulus(1'b0, 1'b1, 8'b1011_0110);
        for (int i = 0; i < 11; i++) applyStimulus(1'b0, 1'b0, 8'h00);

        // Back-to-back B6 then 2D; valid stays high with changing din while
        // the buffer is full, so those words must be ignored
        applyStimulus(1'b0, 1'b1, 8'hB6);
        applyStimulus(1'b0, 1'b1, 8'h2D);
        for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, W'($urandom));
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b0, 8'h00);

        // 0D: LSB-first instance shows 1,0,1,1,0,0,0,0
        applyStimulus(1'b0, 1'b1, 8'h0D);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00);

        // Reset while bit 3 of FF is on x, then B6 from its first bit
        applyStimulus(1'b0, 1'b1, 8'hFF);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        applyStimulus(1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'hB6);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 8'h00);

        // Words separated by 3 idle cycles after each word ends
        for (int n = 0; n < 3; n++) begin
            applyStimulus(1'b0, 1'b1, W'($urandom));
            for (int i = 0; i < W + 3; i++) applyStimulus(1'b0, 1'b0, 8'h00);
        end

        // Randomized traffic with occasional reset
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0), W'($urandom));
        end
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
